ofm_tx_fsm: RTL and testbench

OFM_TX_FSM -- requirements
Module: ofm_tx_fsm

---
 rtl/ofm_tx_fsm.sv | 211 +++++++++++++++++++++
 tb/tb_ofm_tx_fsm.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_tx_fsm.sv
// Outbound frame TX FSM: consumes one txc control frame, then forwards or drops one txd frame
// through a single output register to the MAC. Define OFM_MIN_PAD_EN to pad short frames to 60 B.
module ofm_tx_fsm #(
  parameter int unsigned C_CTRL_WORDS = 6
) (
  input  logic        tx_clk,
  input  logic        tx_reset,
  input  logic [31:0] txc_tdata,
  input  logic [3:0]  txc_tkeep,
  input  logic        txc_tlast,
  input  logic        txc_tvalid,
  output logic        txc_tready,
  input  logic [63:0] txd_tdata,
  input  logic [7:0]  txd_tkeep,
  input  logic        txd_tlast,
  input  logic        txd_tvalid,
  output logic        txd_tready,
  output logic [63:0] tx_axis_mac_tdata,
  output logic [7:0]  tx_axis_mac_tkeep,
  output logic        tx_axis_mac_tlast,
  output logic        tx_axis_mac_tuser,
  output logic        tx_axis_mac_tvalid,
  input  logic        tx_axis_mac_tready,
  output logic        tx_frame_done,
  output logic        tx_frame_drop
);

  localparam int unsigned CtrlCntW = $clog2(C_CTRL_WORDS + 1);

`ifdef OFM_MIN_PAD_EN
  typedef enum logic [2:0] {StIdle, StCtrl, StData, StDrop, StPad} state_e;
`else
  typedef enum logic [2:0] {StIdle, StCtrl, StData, StDrop} state_e;
`endif

  state_e              state_q;
  logic                flag_ok_q;
  logic [CtrlCntW-1:0] ctrl_cnt_q;
  logic [6:0]          byte_cnt_q;
  logic                txc_rdy_q;
  logic [63:0]         out_data_q;
  logic [7:0]          out_keep_q;
  logic                out_last_q;
  logic                out_valid_q;
  logic                done_q;
  logic                drop_q;

  logic       txc_acc;
  logic       txd_acc;
  logic       out_free;
  logic       mac_acc;
  logic [3:0] keep_cnt;
  logic [7:0] byte_sum;
  logic [6:0] byte_sat;

  // Only the flag nibble of word 0 carries meaning here.
  logic unused_txc;
  assign unused_txc = ^{txc_tkeep, txc_tdata[27:0]};

  assign out_free = !out_valid_q || tx_axis_mac_tready;
  assign mac_acc  = out_valid_q && tx_axis_mac_tready;
  assign txc_acc  = txc_tvalid && txc_rdy_q;
  assign txd_acc  = txd_tvalid && txd_tready;

  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < 8; i++) begin
      keep_cnt = keep_cnt + {3'b000, txd_tkeep[i]};
    end
  end

  assign byte_sum = {1'b0, byte_cnt_q} + {4'b0000, keep_cnt};
  assign byte_sat = (byte_sum > 8'd127) ? 7'd127 : byte_sum[6:0];

`ifdef OFM_MIN_PAD_EN
  logic [63:0] txd_masked;
  always_comb begin
    txd_masked = '0;
    for (int i = 0; i < 8; i++) begin
      txd_masked[8*i +: 8] = txd_tdata[8*i +: 8] & {8{txd_tkeep[i]}};
    end
  end
`endif

  always_comb begin
    txd_tready = 1'b0;
    if (state_q == StData) txd_tready = out_free;
    if (state_q == StDrop) txd_tready = 1'b1;
  end

  always_ff @(posedge tx_clk) begin
    if (tx_reset) begin
      state_q     <= StIdle;
      flag_ok_q   <= 1'b0;
      ctrl_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      txc_rdy_q   <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      done_q <= mac_acc && out_last_q;
      drop_q <= 1'b0;
      if (mac_acc) out_valid_q <= 1'b0;

      case (state_q)
        StIdle: begin
          byte_cnt_q <= '0;
          ctrl_cnt_q <= '0;
          txc_rdy_q  <= 1'b1;
          if (txc_acc) begin
            flag_ok_q  <= (txc_tdata[31:28] == 4'hA);
            ctrl_cnt_q <= CtrlCntW'(1);
            if (txc_tlast) begin
              state_q   <= (txc_tdata[31:28] == 4'hA) ? StData : StDrop;
              txc_rdy_q <= 1'b0;
            end else begin
              state_q <= StCtrl;
            end
          end
        end

        StCtrl: begin
          if (txc_acc) begin
            if (ctrl_cnt_q < CtrlCntW'(C_CTRL_WORDS)) ctrl_cnt_q <= ctrl_cnt_q + 1'b1;
            if (txc_tlast) begin
              state_q   <= flag_ok_q ? StData : StDrop;
              txc_rdy_q <= 1'b0;
            end
          end
        end

        StData: begin
          if (txd_acc) begin
            out_valid_q <= 1'b1;
            out_data_q  <= txd_tdata;
            out_keep_q  <= txd_tkeep;
            out_last_q  <= txd_tlast;
            byte_cnt_q  <= byte_sat;
            if (txd_tlast) begin
              state_q   <= StIdle;
              txc_rdy_q <= 1'b1;
            end
`ifdef OFM_MIN_PAD_EN
            // Short frame: zero the stale bytes; beat 7 closes at 60 B, earlier beats go to PAD.
            if (txd_tlast && (byte_sum < 8'd60)) begin
              out_data_q <= txd_masked;
              if (byte_cnt_q == 7'd56) begin
                out_keep_q <= 8'h0F;
              end else begin
                out_keep_q <= 8'hFF;
                out_last_q <= 1'b0;
                byte_cnt_q <= byte_cnt_q + 7'd8;
                state_q    <= StPad;
                txc_rdy_q  <= 1'b0;
              end
            end
`endif
          end
        end

        StDrop: begin
          if (txd_tvalid && txd_tlast) begin
            drop_q    <= 1'b1;
            state_q   <= StIdle;
            txc_rdy_q <= 1'b1;
          end
        end

`ifdef OFM_MIN_PAD_EN
        StPad: begin
          if (out_free && (byte_cnt_q < 7'd60)) begin
            out_valid_q <= 1'b1;
            out_data_q  <= '0;
            if (byte_cnt_q == 7'd56) begin
              out_keep_q <= 8'h0F;
              out_last_q <= 1'b1;
              byte_cnt_q <= 7'd60;
            end else begin
              out_keep_q <= 8'hFF;
              out_last_q <= 1'b0;
              byte_cnt_q <= byte_cnt_q + 7'd8;
            end
          end else if (mac_acc && out_last_q) begin
            state_q   <= StIdle;
            txc_rdy_q <= 1'b1;
          end
        end
`endif

        default: begin
          state_q   <= StIdle;
          txc_rdy_q <= 1'b0;
        end
      endcase
    end
  end

  assign txc_tready         = txc_rdy_q;
  assign tx_axis_mac_tdata  = out_data_q;
  assign tx_axis_mac_tkeep  = out_keep_q;
  assign tx_axis_mac_tlast  = out_last_q;
  assign tx_axis_mac_tuser  = 1'b0;
  assign tx_axis_mac_tvalid = out_valid_q;
  assign tx_frame_done      = done_q;
  assign tx_frame_drop      = drop_q;

endmodule

// File: tb/tb_ofm_tx_fsm.sv
// Scoreboard bench for ofm_tx_fsm: drivers push expected MAC beats, a monitor pops and compares.
module tb_ofm_tx_fsm;

  logic        tx_clk = 1'b0;
  logic        tx_reset = 1'b1;
  logic [31:0] txc_tdata = '0;
  logic [3:0]  txc_tkeep = 4'hF;
  logic        txc_tlast = 1'b0;
  logic        txc_tvalid = 1'b0;
  logic        txc_tready;
  logic [63:0] txd_tdata = '0;
  logic [7:0]  txd_tkeep = '0;
  logic        txd_tlast = 1'b0;
  logic        txd_tvalid = 1'b0;
  logic        txd_tready;
  logic [63:0] tx_axis_mac_tdata;
  logic [7:0]  tx_axis_mac_tkeep;
  logic        tx_axis_mac_tlast;
  logic        tx_axis_mac_tuser;
  logic        tx_axis_mac_tvalid;
  logic        tx_axis_mac_tready = 1'b1;
  logic        tx_frame_done;
  logic        tx_frame_drop;

`ifdef OFM_MIN_PAD_EN
  localparam bit PadEn = 1'b1;
`else
  localparam bit PadEn = 1'b0;
`endif

  ofm_tx_fsm #(.C_CTRL_WORDS(6)) dut (
    .tx_clk             (tx_clk),
    .tx_reset           (tx_reset),
    .txc_tdata          (txc_tdata),
    .txc_tkeep          (txc_tkeep),
    .txc_tlast          (txc_tlast),
    .txc_tvalid         (txc_tvalid),
    .txc_tready         (txc_tready),
    .txd_tdata          (txd_tdata),
    .txd_tkeep          (txd_tkeep),
    .txd_tlast          (txd_tlast),
    .txd_tvalid         (txd_tvalid),
    .txd_tready         (txd_tready),
    .tx_axis_mac_tdata  (tx_axis_mac_tdata),
    .tx_axis_mac_tkeep  (tx_axis_mac_tkeep),
    .tx_axis_mac_tlast  (tx_axis_mac_tlast),
    .tx_axis_mac_tuser  (tx_axis_mac_tuser),
    .tx_axis_mac_tvalid (tx_axis_mac_tvalid),
    .tx_axis_mac_tready (tx_axis_mac_tready),
    .tx_frame_done      (tx_frame_done),
    .tx_frame_drop      (tx_frame_drop)
  );

  always #5 tx_clk = ~tx_clk;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    int          stamp;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    cyc = 0;
  int    done_cnt = 0;
  int    drop_cnt = 0;
  int    mac_beats = 0;
  bit    lat_chk = 1'b0;
  bit    chk_stall = 1'b0;
  bit    toggle_en = 1'b0;
  bit    held_v = 1'b0;
  logic [72:0] held;
  beat_t mon_e;

  always @(posedge tx_clk) cyc <= cyc + 1;

  // MAC ready changes mid high-phase so every negedge sample sees it settled.
  always @(posedge tx_clk) begin
    #1;
    tx_axis_mac_tready = toggle_en ? ~tx_axis_mac_tready : 1'b1;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: got no handshake expected handshake within bound", name);
  endtask

  // Monitor: pops on every MAC handshake, checks stall hold and stall back-pressure.
  always begin
    @(negedge tx_clk);
    #2;
    if (tx_frame_done) done_cnt++;
    if (tx_frame_drop) drop_cnt++;
    if (tx_axis_mac_tvalid) begin
      if (held_v)
        chk("stall_hold", 128'({tx_axis_mac_tdata, tx_axis_mac_tkeep, tx_axis_mac_tlast}),
            128'(held));
      if (!tx_axis_mac_tready) begin
        held_v = 1'b1;
        held   = {tx_axis_mac_tdata, tx_axis_mac_tkeep, tx_axis_mac_tlast};
        if (chk_stall) chk("stall_txd_tready", 128'(txd_tready), 128'(0));
      end else begin
        held_v = 1'b0;
        mac_beats++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got data %h keep %h last %b expected no beat",
                   tx_axis_mac_tdata, tx_axis_mac_tkeep, tx_axis_mac_tlast);
        end else begin
          mon_e = exp_q.pop_front();
          chk("mac_beat", 128'({tx_axis_mac_tdata, tx_axis_mac_tkeep, tx_axis_mac_tlast}),
              128'({mon_e.d, mon_e.k, mon_e.l}));
          if (mon_e.stamp >= 0) chk("latency", 128'(cyc - mon_e.stamp), 128'(1));
        end
      end
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic send_ctrl(input logic [31:0] w, input logic l);
    int n = 0;
    @(negedge tx_clk);
    txd_tvalid = 1'b0;
    txc_tdata  = w;
    txc_tlast  = l;
    txc_tvalid = 1'b1;
    #1;
    while (!txc_tready && n < 200) begin
      @(negedge tx_clk);
      #1;
      n++;
    end
    if (!txc_tready) timeout("txc_handshake");
  endtask

  task automatic txd_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                          input bit push, input beat_t e, input bit want_now);
    int n = 0;
    @(negedge tx_clk);
    txc_tvalid = 1'b0;
    txd_tdata  = d;
    txd_tkeep  = k;
    txd_tlast  = l;
    txd_tvalid = 1'b1;
    #1;
    if (want_now) chk("drop_txd_tready", 128'(txd_tready), 128'(1));
    while (!txd_tready && n < 200) begin
      @(negedge tx_clk);
      #1;
      n++;
    end
    if (!txd_tready) timeout("txd_handshake");
    if (push) begin
      e.stamp = lat_chk ? cyc : -1;
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [63:0] pat(input logic [63:0] base, input int i);
    return base + 64'(i) * 64'h0101_0101_0101_0101;
  endfunction

  task automatic send_frame(input logic [31:0] flag, input int napp, input int nbeats,
                            input logic [7:0] lastkeep, input bit fwd, input logic [63:0] base);
    int    total;
    beat_t e;
    logic [63:0] md;
    send_ctrl(flag, napp == 0);
    for (int i = 0; i < napp; i++) send_ctrl(32'h0000_1000 + i, i == napp - 1);
    total = 8 * (nbeats - 1) + $countones(lastkeep);
    for (int i = 0; i < nbeats; i++) begin
      e.d = pat(base, i);
      e.k = (i == nbeats - 1) ? lastkeep : 8'hFF;
      e.l = (i == nbeats - 1);
      e.stamp = -1;
      if (PadEn && e.l && total < 60) begin
        md = '0;
        for (int b = 0; b < 8; b++) if (lastkeep[b]) md[8*b +: 8] = e.d[8*b +: 8];
        if (nbeats == 8) begin
          e.k = 8'h0F;
        end else begin
          e.k = 8'hFF;
          e.l = 1'b0;
        end
        txd_beat(pat(base, i), lastkeep, 1'b1, fwd, '{md, e.k, e.l, -1}, !fwd);
      end else begin
        txd_beat(e.d, e.k, e.l, fwd, e, !fwd);
      end
    end
    if (PadEn && fwd && total < 60 && nbeats < 8) begin
      for (int b = nbeats; b < 7; b++) exp_q.push_back('{64'h0, 8'hFF, 1'b0, -1});
      exp_q.push_back('{64'h0, 8'h0F, 1'b1, -1});
    end
    @(negedge tx_clk);
    txd_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || tx_axis_mac_tvalid) && n < 300) begin
      @(negedge tx_clk);
      n++;
    end
    if (n >= 300) timeout("drain");
    repeat (3) @(negedge tx_clk);
  endtask

  initial begin
    int d0;
    int p0;
    int b0;

    repeat (3) @(negedge tx_clk);
    #1;
    chk("rst_mac_out", 128'({tx_axis_mac_tvalid, tx_axis_mac_tlast, tx_axis_mac_tuser,
        tx_axis_mac_tkeep, tx_axis_mac_tdata}), 128'(0));
    chk("rst_ready", 128'({txc_tready, txd_tready}), 128'(0));
    chk("rst_pulse", 128'({tx_frame_done, tx_frame_drop}), 128'(0));
    tx_reset = 1'b0;
    @(negedge tx_clk);
    #1;
    chk("idle_txc_tready", 128'(txc_tready), 128'(1));
    chk("idle_txd_tready", 128'(txd_tready), 128'(0));

    // 16-beat frame, MAC always ready, one-cycle latency per beat
    d0 = done_cnt; p0 = drop_cnt; b0 = mac_beats;
    lat_chk = 1'b1;
    send_frame(32'hA000_0000, 5, 16, 8'h0F, 1'b1, 64'h1000_0000_0000_0000);
    drain();
    lat_chk = 1'b0;
    chk("t1_beats", 128'(mac_beats - b0), 128'(16));
    chk("t1_done", 128'(done_cnt - d0), 128'(1));
    chk("t1_drop", 128'(drop_cnt - p0), 128'(0));

    // Bad flag: whole frame dropped, next frame forwarded
    d0 = done_cnt; p0 = drop_cnt; b0 = mac_beats;
    send_frame(32'h5000_0000, 0, 4, 8'hFF, 1'b0, 64'h2000_0000_0000_0000);
    drain();
    chk("t2_drop", 128'(drop_cnt - p0), 128'(1));
    chk("t2_no_out", 128'(mac_beats - b0), 128'(0));
    chk("t2_no_done", 128'(done_cnt - d0), 128'(0));
    d0 = done_cnt;
    send_frame(32'hA000_0000, 5, 8, 8'hFF, 1'b1, 64'h3000_0000_0000_0000);
    drain();
    chk("t2_next_done", 128'(done_cnt - d0), 128'(1));

    // MAC ready toggling every cycle
    d0 = done_cnt; b0 = mac_beats;
    toggle_en = 1'b1;
    chk_stall = 1'b1;
    send_frame(32'hA000_0000, 5, 16, 8'h0F, 1'b1, 64'h4000_0000_0000_0000);
    drain();
    toggle_en = 1'b0;
    chk_stall = 1'b0;
    repeat (2) @(negedge tx_clk);
    chk("t3_beats", 128'(mac_beats - b0), 128'(16));
    chk("t3_done", 128'(done_cnt - d0), 128'(1));

    // 18-byte frame: padded to 8 beats only when padding is built in
    d0 = done_cnt; b0 = mac_beats;
    send_frame(32'hA000_0000, 5, 3, 8'h03, 1'b1, 64'h5000_0000_0000_00F0);
    drain();
    chk("t4_beats", 128'(mac_beats - b0), 128'(PadEn ? 8 : 3));
    chk("t4_done", 128'(done_cnt - d0), 128'(1));

    // 58-byte frame ending on beat 7; extra control words beyond the frame size
    b0 = mac_beats;
    send_frame(32'hA000_0000, 5, 8, 8'h03, 1'b1, 64'h6000_0000_0000_0000);
    drain();
    chk("t5_beats", 128'(mac_beats - b0), 128'(8));
    b0 = mac_beats;
    send_frame(32'hA000_0000, 9, 2, 8'hFF, 1'b1, 64'h7000_0000_0000_0000);
    drain();
    chk("t6_beats", 128'(mac_beats - b0), 128'(PadEn ? 8 : 2));

    // Reset during beat 5 of a 10-beat frame
    d0 = done_cnt;
    send_ctrl(32'hA000_0000, 1'b0);
    for (int i = 0; i < 5; i++) send_ctrl(32'h0000_2000 + i, i == 4);
    for (int i = 0; i < 5; i++)
      txd_beat(pat(64'h8000_0000_0000_0000, i), 8'hFF, 1'b0, 1'b1,
               '{pat(64'h8000_0000_0000_0000, i), 8'hFF, 1'b0, -1}, 1'b0);
    @(negedge tx_clk);
    txd_tvalid = 1'b0;
    tx_reset   = 1'b1;
    @(negedge tx_clk);
    tx_reset = 1'b0;
    #1;
    chk("r2_mac_out", 128'({tx_axis_mac_tvalid, tx_axis_mac_tlast, tx_axis_mac_tuser,
        tx_axis_mac_tkeep, tx_axis_mac_tdata}), 128'(0));
    chk("r2_ready", 128'({txc_tready, txd_tready}), 128'(0));
    chk("r2_pulse", 128'({tx_frame_done, tx_frame_drop}), 128'(0));
    drain();
    chk("r2_no_done", 128'(done_cnt - d0), 128'(0));
    b0 = mac_beats;
    send_frame(32'hA000_0000, 5, 10, 8'hFF, 1'b1, 64'h9000_0000_0000_0000);
    drain();
    chk("r2_after_beats", 128'(mac_beats - b0), 128'(10));
    chk("r2_after_done", 128'(done_cnt - d0), 128'(1));
    chk("queue_empty", 128'(exp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
